fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Consumes the redirect controls produced by the decode-stage controller (pc_control, npcsel) plus the decode-stage rs value, and computes the next PC itself.
- Supplies the decode stage with the instruction, its PC, its link address and a fetch-fault flag. MIPS branch-delay-slot semantics apply: the F-stage instruction is never flushed.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_AW, 10, instruction-memory word-address width (IM_WORDS = 2**IM_AW).

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard hold; freezes PC and IF/ID
- pc_control  in  2  0 = sequential, 1 = branch/jump target, 2 = register target, 3 = reserved (treated as 0)
- npcsel  in  1  with pc_control==1: 1 = j/jal target, 0 = beq target
- rs_d  in  32  forwarded rs value of the D-stage instruction (jr/jalr target)
- imem_addr  out  IM_AW  word address to instruction memory (combinational read)
- imem_rdata  in  32  instruction word at imem_addr, same cycle
- pc_f  out  32  current fetch PC
- instr_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc8_d  out  32  IF/ID PC+8 (jal/jalr link value)
- fault_d  out  1  IF/ID fetch-fault flag

Behaviour:
- Reset (asynchronous, immediate):
  - pc_f = RESET_PC.
  - instr_d = 32'h0 (nop); pc_d = 0; pc8_d = 0; fault_d = 0.
- Address generation (combinational):
  - off = pc_f - IM_BASE.
  - imem_addr = off[IM_AW+1:2].
  - fault_f = (pc_f[1:0] != 0) OR (pc_f < IM_BASE) OR (off[31:IM_AW+2] != 0).
  - instr_f = fault_f ? 32'h0 : imem_rdata.
- Target computation (combinational, from IF/ID contents):
  - pc4_d = pc_d + 4.
  - br_tgt = pc4_d + ({{14{instr_d[15]}}, instr_d[15:0], 2'b00}); 32-bit wrap on overflow.
  - j_tgt = {pc4_d[31:28], instr_d[25:0], 2'b00}.
  - r_tgt = rs_d, used unmodified. A misaligned value is not corrected; it shows up as fault_f on the next fetch.
- Next-PC selection:
  - npc = pc_control==1 ? (npcsel ? j_tgt : br_tgt) : pc_control==2 ? r_tgt : pc_f + 4.
  - pc_f + 4 wraps modulo 2^32.
- Rising edge with stall=0:
  - pc_f <= npc.
  - instr_d <= instr_f; pc_d <= pc_f; pc8_d <= pc_f + 8; fault_d <= fault_f.
- Rising edge with stall=1:
  - pc_f, instr_d, pc_d, pc8_d and fault_d all hold.
  - The redirect inputs are ignored that cycle. Because IF/ID holds, the D-stage controller re-presents the same redirect, and it takes effect on the first edge with stall=0.
- Delay slot: a redirect loads the target into pc_f, while the instruction already fetched at pc_f (the delay slot) advances into IF/ID normally. No kill signal exists.
- Back-to-back redirects need no special case. A branch in the delay slot of a jump redirects relative to its own pc_d.
- Latency:
  - Fetch to IF/ID takes 1 cycle.
  - A redirect decided in D is visible at pc_f 1 cycle later.
- Faulted fetch:
  - A nop enters IF/ID with fault_d=1.
  - pc_f continues sequentially (or follows a redirect). The fetch unit raises no exception itself.
- Reset mid-stall or mid-redirect: reset wins and all state returns to reset values immediately.

Test Plan:
- Reset then 3 edges, stall=0, pc_control=0, memory words 0..2 = A,B,C:
  - pc_f follows 3000, 3004, 3008, 300C.
  - After edge 3: instr_d=C, pc_d=3008, pc8_d=3010.
  - fault_d=0 throughout.
- beq redirect: instr_d=32'h1000FFFE with pc_d=3010, pc_control=1, npcsel=0:
  - Next pc_f = 3010+4-8 = 300C.
  - The delay slot at 3014 enters IF/ID with pc_d=3014.
- jal redirect: instr_d=32'h0C000C10 with pc_d=3020, pc_control=1, npcsel=1:
  - Next pc_f = 00003040; pc8_d of the jal = 3028.
- jr to misaligned address: pc_control=2, rs_d=32'h00003042:
  - pc_f = 3042.
  - Next edge: instr_d=0, fault_d=1.
  - pc_f = 3046, which also faults.
- Stall with pending redirect: stall=1 for 2 cycles while pc_control=1 (j to 3100):
  - All outputs unchanged for both cycles.
  - First edge after stall drops: pc_f=3100.
- Out-of-range fetch: pc_f = IM_BASE + 4*IM_WORDS:
  - instr_d=0, fault_d=1.
  - Assert reset asynchronously mid-cycle: pc_f=3000 and fault_d=0 before the next edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and next-PC selection.
// Redirects come from the decode-stage controller; the delay-slot instruction is never flushed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_AW    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [1:0]       pc_control,
    input  logic             npcsel,
    input  logic [31:0]      rs_d,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d,
    output logic             fault_d
);

    logic [31:0] off;
    logic        fault_f;
    logic [31:0] instr_f;
    logic [31:0] pc4_d;
    logic [31:0] br_tgt;
    logic [31:0] j_tgt;
    logic [31:0] npc;

    always_comb begin
        off       = pc_f - IM_BASE;
        imem_addr = off[IM_AW+1:2];
        fault_f   = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) ||
                    ((off >> (IM_AW + 2)) != '0);
        instr_f   = fault_f ? '0 : imem_rdata;
    end

    always_comb begin
        pc4_d  = pc_d + 32'd4;
        br_tgt = pc4_d + {{14{instr_d[15]}}, instr_d[15:0], 2'b00};
        j_tgt  = {pc4_d[31:28], instr_d[25:0], 2'b00};
        npc    = pc_f + 32'd4;
        case (pc_control)
            2'd1:    npc = npcsel ? j_tgt : br_tgt;
            2'd2:    npc = rs_d;
            default: npc = pc_f + 32'd4;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_f    <= RESET_PC;
            instr_d <= '0;
            pc_d    <= '0;
            pc8_d   <= '0;
            fault_d <= 1'b0;
        end else if (!stall) begin
            pc_f    <= npc;
            instr_d <= instr_f;
            pc_d    <= pc_f;
            pc8_d   <= pc_f + 32'd8;
            fault_d <= fault_f;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a combinational instruction-memory model.
module tb_fetch_unit;

    localparam int IM_AW    = 10;
    localparam int IM_WORDS = 2 ** IM_AW;

    logic             clk = 1'b0;
    logic             reset;
    logic             stall;
    logic [1:0]       pc_control;
    logic             npcsel;
    logic [31:0]      rs_d;
    logic [IM_AW-1:0] imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      pc_f;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
    logic             fault_d;

    logic [31:0] mem [0:IM_WORDS-1];

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .RESET_PC(32'h0000_3000),
        .IM_BASE (32'h0000_3000),
        .IM_AW   (IM_AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .pc_control(pc_control),
        .npcsel    (npcsel),
        .rs_d      (rs_d),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .pc_f      (pc_f),
        .instr_d   (instr_d),
        .pc_d      (pc_d),
        .pc8_d     (pc8_d),
        .fault_d   (fault_d)
    );

    always #5 clk = ~clk;

    assign imem_rdata = mem[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int unsigned i = 0; i < IM_WORDS; i++) mem[i] = 32'h2400_0000 + i;
        mem[4]    = 32'h1000_FFFE;  // beq at 3010, offset -2
        mem[8]    = 32'h0C00_0C10;  // jal 3040 at 3020
        mem[32]   = 32'h0800_0C40;  // j 3100 at 3080
        reset      = 1'b1;
        stall      = 1'b0;
        pc_control = 2'd0;
        npcsel     = 1'b0;
        rs_d       = '0;
        #12;
        check_eq("rst_pc_f",    pc_f,    32'h3000);
        check_eq("rst_instr_d", instr_d, 32'h0);
        check_eq("rst_pc_d",    pc_d,    32'h0);
        check_eq("rst_pc8_d",   pc8_d,   32'h0);
        check_eq("rst_fault_d", {31'b0, fault_d}, 32'h0);
        check_eq("rst_imem_addr", {22'b0, imem_addr}, 32'h0);
        reset = 1'b0;

        // sequential fetch
        step(); check_eq("seq1_pc_f", pc_f, 32'h3004);
        check_eq("seq1_instr_d", instr_d, 32'h2400_0000);
        check_eq("seq1_fault", {31'b0, fault_d}, 32'h0);
        step(); check_eq("seq2_pc_f", pc_f, 32'h3008);
        check_eq("seq2_fault", {31'b0, fault_d}, 32'h0);
        step(); check_eq("seq3_pc_f", pc_f, 32'h300C);
        check_eq("seq3_instr_d", instr_d, 32'h2400_0002);
        check_eq("seq3_pc_d",    pc_d,    32'h3008);
        check_eq("seq3_pc8_d",   pc8_d,   32'h3010);
        check_eq("seq3_fault",   {31'b0, fault_d}, 32'h0);
        check_eq("seq3_imem_addr", {22'b0, imem_addr}, 32'h3);

        // beq backwards
        step(); check_eq("seq4_pc_f", pc_f, 32'h3010);
        step(); check_eq("beq_instr_d", instr_d, 32'h1000_FFFE);
        check_eq("beq_pc_d", pc_d, 32'h3010);
        pc_control = 2'd1; npcsel = 1'b0;
        step(); check_eq("beq_tgt_pc_f", pc_f, 32'h300C);
        check_eq("beq_slot_pc_d", pc_d, 32'h3014);
        check_eq("beq_slot_instr", instr_d, 32'h2400_0005);

        // jr to 3020, then jal
        pc_control = 2'd2; rs_d = 32'h3020;
        step(); check_eq("jr3020_pc_f", pc_f, 32'h3020);
        pc_control = 2'd0;
        step(); check_eq("jal_instr_d", instr_d, 32'h0C00_0C10);
        check_eq("jal_pc8_d", pc8_d, 32'h3028);
        pc_control = 2'd1; npcsel = 1'b1;
        step(); check_eq("jal_tgt_pc_f", pc_f, 32'h3040);
        check_eq("jal_slot_pc_d", pc_d, 32'h3024);

        // jr to misaligned address
        pc_control = 2'd2; rs_d = 32'h3042;
        step(); check_eq("jrmis_pc_f", pc_f, 32'h3042);
        pc_control = 2'd0;
        step(); check_eq("mis_instr_d", instr_d, 32'h0);
        check_eq("mis_fault_d", {31'b0, fault_d}, 32'h1);
        check_eq("mis_pc_d", pc_d, 32'h3042);
        check_eq("mis_next_pc_f", pc_f, 32'h3046);
        step(); check_eq("mis2_fault_d", {31'b0, fault_d}, 32'h1);
        check_eq("mis2_pc_d", pc_d, 32'h3046);

        // stall with pending j 3100
        pc_control = 2'd2; rs_d = 32'h3080;
        step(); check_eq("jr3080_pc_f", pc_f, 32'h3080);
        pc_control = 2'd0;
        step(); check_eq("j_instr_d", instr_d, 32'h0800_0C40);
        stall = 1'b1; pc_control = 2'd1; npcsel = 1'b1;
        for (int unsigned k = 0; k < 2; k++) begin
            step();
            check_eq("stall_pc_f",    pc_f,    32'h3084);
            check_eq("stall_instr_d", instr_d, 32'h0800_0C40);
            check_eq("stall_pc_d",    pc_d,    32'h3080);
            check_eq("stall_pc8_d",   pc8_d,   32'h3088);
            check_eq("stall_fault_d", {31'b0, fault_d}, 32'h0);
        end
        stall = 1'b0;
        step(); check_eq("unstall_pc_f", pc_f, 32'h3100);
        check_eq("unstall_pc_d", pc_d, 32'h3084);

        // below IM_BASE faults
        pc_control = 2'd2; rs_d = 32'h2FFC;
        step(); check_eq("low_pc_f", pc_f, 32'h2FFC);
        pc_control = 2'd0;
        step(); check_eq("low_fault_d", {31'b0, fault_d}, 32'h1);
        check_eq("low_instr_d", instr_d, 32'h0);

        // last valid word, then one past the end
        pc_control = 2'd2; rs_d = 32'h3FFC;
        step(); check_eq("last_pc_f", pc_f, 32'h3FFC);
        pc_control = 2'd0;
        step(); check_eq("last_instr_d", instr_d, 32'h2400_03FF);
        check_eq("last_fault_d", {31'b0, fault_d}, 32'h0);
        check_eq("oor_pc_f", pc_f, 32'h4000);
        step(); check_eq("oor_instr_d", instr_d, 32'h0);
        check_eq("oor_fault_d", {31'b0, fault_d}, 32'h1);
        check_eq("oor_pc_d", pc_d, 32'h4000);
        check_eq("oor_pc8_d", pc8_d, 32'h4008);

        // asynchronous reset mid-cycle
        #2 reset = 1'b1;
        #1;
        check_eq("arst_pc_f",    pc_f,    32'h3000);
        check_eq("arst_fault_d", {31'b0, fault_d}, 32'h0);
        check_eq("arst_instr_d", instr_d, 32'h0);
        check_eq("arst_pc_d",    pc_d,    32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
